// File: rtl/alu_shift_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_exec_unit
//  Purpose  : Single-command ALU/shifter responder with valid/ready command
//             and response channels. Optional single-cycle barrel shifter is
//             enabled by defining ALU_SHIFT_EXEC_BARREL_SHIFT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_exec_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_sel,
    input  logic [67:0]      cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [33:0]      rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ALU_EX = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [67:0]      cmd_q, cmd_d;
    logic [33:0]      rsp_q, rsp_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    // ALU datapath, operating on the latched command word
    logic [31:0] w_a, w_b, w_sum, w_alu_res;
    logic        w_cin, w_ovf_add, w_alu_ovf;
    logic [33:0] w_alu_rsp;
    logic        w_lr;
    logic [4:0]  w_shamt;

    assign w_a       = cmd_q[67] ? ~cmd_q[63:32] : cmd_q[63:32];
    assign w_b       = cmd_q[66] ? ~cmd_q[31:0]  : cmd_q[31:0];
    assign w_cin     = cmd_q[66];
    assign w_sum     = w_a + w_b + {31'b0, w_cin};
    assign w_ovf_add = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
    assign w_lr      = cmd_q[37];
    assign w_shamt   = cmd_q[36:32];

    always_comb begin
        w_alu_res = 32'b0;
        w_alu_ovf = 1'b0;
        case (cmd_q[65:64])
            2'b00:   w_alu_res = w_a & w_b;
            2'b01:   w_alu_res = w_a | w_b;
            2'b10: begin
                w_alu_res = w_sum;
                w_alu_ovf = w_ovf_add;
            end
            default: w_alu_res = {31'b0, w_sum[31] ^ w_ovf_add};
        endcase
    end

    assign w_alu_rsp = {w_alu_ovf, (w_alu_res == 32'b0), w_alu_res};

`ifdef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
    logic [31:0] w_barrel;
    assign w_barrel = w_lr ? (cmd_q[31:0] << w_shamt) : (cmd_q[31:0] >> w_shamt);
`else
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] w_step;

    // shamt of zero still spends one cycle in SHIFT, but without moving bits
    assign w_step = (w_shamt == 5'd0) ? work_q :
                    (w_lr ? {work_q[30:0], 1'b0} : {1'b0, work_q[31:1]});
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_sel ? S_SHIFT : S_ALU_EX;
                end
            end
            S_ALU_EX: state_d = S_RESP;
            S_SHIFT: begin
`ifdef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
                state_d = S_RESP;
`else
                if (cnt_q == 5'd1) begin
                    state_d = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
    end

    // Datapath next-value logic
    always_comb begin
        cmd_d = cmd_q;
        rsp_d = rsp_q;
        ops_d = ops_q;
`ifndef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
        work_d = work_q;
        cnt_d  = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd_data;
`ifndef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
                    work_d = cmd_data[31:0];
                    cnt_d  = (cmd_data[36:32] == 5'd0) ? 5'd1 : cmd_data[36:32];
`endif
                end
            end
            S_ALU_EX: rsp_d = w_alu_rsp;
            S_SHIFT: begin
`ifdef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
                rsp_d = {2'b00, w_barrel};
`else
                work_d = w_step;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    rsp_d = {2'b00, w_step};
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ops_d = ops_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q <= 68'b0;
            rsp_q <= 34'b0;
            ops_q <= '0;
`ifndef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
            work_q <= 32'b0;
            cnt_q  <= 5'b0;
`endif
        end else begin
            cmd_q <= cmd_d;
            rsp_q <= rsp_d;
            ops_q <= ops_d;
`ifndef ALU_SHIFT_EXEC_BARREL_SHIFT_EN
            work_q <= work_d;
            cnt_q  <= cnt_d;
`endif
        end
    end

    assign rsp_data = rsp_q;
    assign ops_done = ops_q;

endmodule
`default_nettype wire

// File: doc/alu_shift_exec_unit.md
Name: alu_shift_exec_unit

Overview:
- Hardware responder for the packed ALU/Shifter test-vector format: accepts one 68-bit command word, executes it, and returns one 34-bit answer word {overflow, zero, result}.
- Sits behind a command sequencer or vector player. Commands arrive and responses leave over valid/ready handshakes, one command in flight at a time.
- ALU ops complete in one execute cycle. Shifts are iterative, one bit per cycle.

Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command word present.
- cmd_ready  output  1  block accepts a command this cycle.
- cmd_sel  input  1  0 = ALU command, 1 = shifter command.
- cmd_data  input  68  command word; format below.
- rsp_valid  output  1  answer word present.
- rsp_ready  input  1  consumer accepts the answer.
- rsp_data  output  34  answer: [33] overflow, [32] zero, [31:0] result.
- busy  output  1  high in any state other than IDLE.
- ops_done  output  CNT_W  count of answers consumed; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, rst=1 at a posedge): state IDLE; cmd_ready=1, rsp_valid=0, rsp_data=0, busy=0, ops_done=0. Any command in flight is discarded with no response.
- ALU command format: [67] invertA, [66] invertB, [65:64] operation, [63:32] src1, [31:0] src2.
- Shifter command format: [37] leftRight, [36:32] shamt, [31:0] src. Bits [67:38] ignored.
- Operand and carry setup: A' = invertA ? ~src1 : src1; B' = invertB ? ~src2 : src2; carry-in = invertB.
- operation 00: result = A' & B'.
- operation 01: result = A' | B'.
- operation 10: result = A' + B' + cin, mod 2^32; overflow = signed overflow of that add.
- operation 11 (SLT): result = {31'b0, sum[31] ^ ovf_add}. ovf_add is computed internally but overflow is reported as 0.
- ALU overflow: 0 for all operations except 10.
- ALU zero flag: (result == 0).
- Shifter: leftRight=1 is logical left, 0 is logical right, shift by shamt; zero-fill. rsp_data[33:32] = 2'b00 for all shifter commands.
- FSM states: IDLE, ALU_EX, SHIFT, RESP.
- IDLE: cmd_ready=1. On cmd_valid at a posedge, latch cmd_sel and cmd_data; go to ALU_EX if cmd_sel=0. For cmd_sel=1, go to SHIFT, with step counter = max(shamt,1) when the build has no BARREL_SHIFT_EN.
- ALU_EX: compute and register the answer; go to RESP on the next posedge. ALU latency is accept edge + 1, so rsp_valid is seen 1 cycle after the accept edge.
- SHIFT: shift the working register by 1 bit per cycle in the latched direction and decrement the counter. shamt=0 takes one pass-through cycle with no shift. Go to RESP when the counter reaches 1. Latency = max(shamt,1) cycles.
- RESP: rsp_valid=1 and rsp_data is held stable. On rsp_ready at a posedge, ops_done increments (wrapping from all-ones to 0) and the state returns to IDLE.
- cmd_ready=0 in every state except IDLE. cmd_valid is ignored there, and the command is not consumed.
- No back-to-back overlap: after a response is consumed, the next command is accepted no earlier than the following cycle.
- cmd_data is sampled only on the accept edge. Later changes have no effect.

Optional Feature:
- Macro: ALU_SHIFT_EXEC_BARREL_SHIFT_EN.
- Defined: SHIFT completes in one cycle via a combinational barrel shifter, so every shifter command has latency 1, identical to ALU timing.
- Undefined: iterative one-bit-per-cycle shifter as specified under Behaviour.
- Answer values are identical in both builds.

Test Plan:
- ALU add overflow: invA=0, invB=0, op=10, src1=0x7FFFFFFF, src2=0x00000001 -> rsp_data = {1,0,0x80000000}; rsp_valid 1 cycle after accept.
- SUB equal and NOR:
  - invB=1, op=10, 5 - 5 -> {0,1,0x00000000}.
  - invA=1, invB=1, op=00, 0 and 0 -> {0,0,0xFFFFFFFF}.
- SLT with signed operands: invB=1, op=11, src1=0xFFFFFFFF, src2=0x00000001 -> {0,0,0x00000001}. Then src1=0x80000000, src2=0x7FFFFFFF -> result 1 (overflow-corrected).
- Shifts:
  - cmd_sel=1, leftRight=1, shamt=4, src=0x000000F1 -> result 0x00000F10, rsp_valid 4 cycles after accept (1 cycle with BARREL_SHIFT_EN).
  - leftRight=0, shamt=0, src=0x12345678 -> 0x12345678 after 1 cycle.
- Backpressure: hold rsp_ready=0 for 3 cycles -> rsp_data stable, cmd_ready=0, a cmd_valid pulse is not consumed; ops_done increments by exactly 1 on release.
- Reset mid-shift: shamt=31 command, assert rst in cycle 10 -> next cycle rsp_valid=0, cmd_ready=1, ops_done=0, and no stale answer appears afterwards.
